// File: rtl/nandgame_pkg.sv
// rtl/nandgame_pkg.sv - shared state type and instruction field positions for the nandgame sequencer
package nandgame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_EXEC,
        ST_STORE
    } state_t;

    localparam int CI     = 15;
    localparam int A_SEL  = 12;
    localparam int DST_HI = 5;
    localparam int DST_LO = 3;
    localparam int JMP_HI = 2;
    localparam int JMP_LO = 0;

    // Bit positions inside the 3-bit decoder destination field
    localparam int DST_A = 2;
    localparam int DST_D = 1;
    localparam int DST_M = 0;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    // C-instructions that select *A as the Y operand need a data read before execute
    function automatic logic needs_load(input logic [15:0] instr);
        return instr[CI] & instr[A_SEL];
    endfunction

endpackage

// File: rtl/nandgame_sequencer.sv
// rtl/nandgame_sequencer.sv - multi-cycle fetch/load/execute/store control FSM owning PC, A and D
module nandgame_sequencer
    import nandgame_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_valid,
    output logic [15:0] dec_instruction,
    output logic [15:0] dec_a_reg,
    output logic [15:0] dec_d_reg,
    output logic [15:0] dec_a_mem_reg,
    input  logic [15:0] dec_out,
    input  logic        dec_jmp,
    input  logic [2:0]  dec_dst,
    output logic [15:0] pc,
    output logic        retire
);

    state_t      state_q, state_d;
    logic [15:0] pc_q;
    logic [15:0] a_q;
    logic [15:0] d_q;
    logic [15:0] ir_q;
    logic [15:0] mr_q;
    logic [15:0] st_addr_q;
    logic [15:0] st_data_q;
    logic        retire_q;
    logic        retire_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        retire_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_valid) state_d = needs_load(imem_rdata) ? ST_LOAD : ST_EXEC;
            end
            ST_LOAD: begin
                if (dmem_valid) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (dec_dst[DST_M]) begin
                    state_d = ST_STORE;
                end else begin
                    retire_d = 1'b1;
                    state_d  = run ? ST_FETCH : ST_IDLE;
                end
            end
            ST_STORE: begin
                if (dmem_valid) begin
                    retire_d = 1'b1;
                    state_d  = run ? ST_FETCH : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Jump target and store address both use A as it was before this instruction's commit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            a_q       <= '0;
            d_q       <= '0;
            ir_q      <= '0;
            mr_q      <= '0;
            st_addr_q <= '0;
            st_data_q <= '0;
            retire_q  <= 1'b0;
        end else begin
            retire_q <= retire_d;
            case (state_q)
                ST_FETCH: begin
                    if (imem_valid) ir_q <= imem_rdata;
                end
                ST_LOAD: begin
                    if (dmem_valid) mr_q <= dmem_rdata;
                end
                ST_EXEC: begin
                    if (dec_dst[DST_A]) a_q <= dec_out;
                    if (dec_dst[DST_D]) d_q <= dec_out;
                    pc_q <= dec_jmp ? a_q : pc_q + 16'd1;
                    if (dec_dst[DST_M]) begin
                        st_addr_q <= a_q;
                        st_data_q <= dec_out;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_req        = (state_q == ST_FETCH);
    assign imem_addr       = pc_q;
    assign dmem_req        = (state_q == ST_LOAD) || (state_q == ST_STORE);
    assign dmem_we         = (state_q == ST_STORE);
    assign dmem_addr       = (state_q == ST_STORE) ? st_addr_q : a_q;
    assign dmem_wdata      = st_data_q;
    assign dec_instruction = ir_q;
    assign dec_a_reg       = a_q;
    assign dec_d_reg       = d_q;
    assign dec_a_mem_reg   = mr_q;
    assign pc              = pc_q;
    assign retire          = retire_q;

endmodule

// File: tb/tb_nandgame_sequencer.sv
// tb/tb_nandgame_sequencer.sv - scoreboard bench for nandgame_sequencer with ISA reference model
module tb_nandgame_sequencer;
    import nandgame_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        imem_valid = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata = '0;
    logic        dmem_valid = 1'b0;
    logic [15:0] dec_instruction;
    logic [15:0] dec_a_reg;
    logic [15:0] dec_d_reg;
    logic [15:0] dec_a_mem_reg;
    logic [15:0] dec_out;
    logic        dec_jmp;
    logic [2:0]  dec_dst;
    logic [15:0] pc;
    logic        retire;

    always #5 clk = ~clk;

    nandgame_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_valid(dmem_valid),
        .dec_instruction(dec_instruction), .dec_a_reg(dec_a_reg), .dec_d_reg(dec_d_reg),
        .dec_a_mem_reg(dec_a_mem_reg), .dec_out(dec_out), .dec_jmp(dec_jmp), .dec_dst(dec_dst),
        .pc(pc), .retire(retire)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [15:0] prog     [0:255];
    logic [15:0] dmem_arr [0:255];
    logic [15:0] m_mem    [0:255];
    logic [15:0] m_pc, m_a, m_d;
    int          imem_wait = 0;
    int          dmem_wait = 0;
    bit          dresp_en = 1'b1;
    bit          dmem_force = 1'b0;
    logic [47:0] exp_q[$];
    logic [31:0] st_q[$];
    logic [15:0] fetch_log[$];
    int          ret_cyc[$];
    int          load_cnt = 0;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference nandgame decoder/ALU: returns {out[15:0], jmp, dst[2:0]}
    function automatic logic [19:0] decode(input logic [15:0] ir, input logic [15:0] a,
                                           input logic [15:0] d, input logic [15:0] m);
        logic [15:0] xv, yv, ysel, r;
        logic        j;
        if (!ir[CI]) return {ir, 1'b0, 3'b100};
        ysel = ir[A_SEL] ? m : a;
        xv   = ir[6] ? ysel : d;
        yv   = ir[6] ? d : ysel;
        if (ir[7]) xv = '0;
        case (ir[10:8])
            3'b000:  r = xv & yv;
            3'b001:  r = xv | yv;
            3'b010:  r = xv ^ yv;
            3'b011:  r = ~xv;
            3'b100:  r = xv + yv;
            3'b101:  r = xv + 16'd1;
            3'b110:  r = xv - yv;
            default: r = xv - 16'd1;
        endcase
        j = (ir[JMP_HI] && r[15]) || (ir[JMP_HI-1] && r == 16'd0) || (ir[JMP_LO] && !r[15] && r != 16'd0);
        return {r, j, ir[DST_HI:DST_LO]};
    endfunction

    assign {dec_out, dec_jmp, dec_dst} = decode(dec_instruction, dec_a_reg, dec_d_reg, dec_a_mem_reg);

    task automatic iss_run(input int n);
        logic [19:0] r;
        logic [15:0] ir;
        for (int i = 0; i < n; i++) begin
            ir = prog[m_pc[7:0]];
            r  = decode(ir, m_a, m_d, m_mem[m_a[7:0]]);
            if (r[0]) begin
                st_q.push_back({m_a, r[19:4]});
                m_mem[m_a[7:0]] = r[19:4];
            end
            m_pc = r[3] ? m_a : m_pc + 16'd1;
            if (r[2]) m_a = r[19:4];
            if (r[1]) m_d = r[19:4];
            exp_q.push_back({m_pc, m_a, m_d});
        end
    endtask

    function automatic logic [15:0] log_at(input int i);
        if (i < fetch_log.size()) return fetch_log[i];
        return 16'hxxxx;
    endfunction

    function automatic int ret_gap(input int i);
        if (i < ret_cyc.size() && i > 0) return ret_cyc[i] - ret_cyc[i-1];
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    bit          i_busy = 1'b0;
    bit          d_busy = 1'b0;
    logic [15:0] i_hold;
    logic [32:0] d_hold;
    int          icnt = 0;
    int          dcnt = 0;

    // Monitor first (sees the valid the DUT just consumed), then the memory responders
    always @(negedge clk) begin : mon_resp
        logic [47:0] e;
        logic [31:0] s;
        if (retire) begin
            ret_cyc.push_back(cyc);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("retire_pc", 48'(pc), 48'(e[47:32]));
                check("retire_a", 48'(dec_a_reg), 48'(e[31:16]));
                check("retire_d", 48'(dec_d_reg), 48'(e[15:0]));
            end
        end
        if (imem_req) begin
            if (i_busy && !imem_valid) check("imem_addr_stable", 48'(imem_addr), 48'(i_hold));
            else begin
                i_hold = imem_addr;
                fetch_log.push_back(imem_addr);
            end
            i_busy = 1'b1;
        end else i_busy = 1'b0;
        if (dmem_req) begin
            if (d_busy && !dmem_valid) check("dmem_req_stable", 48'({dmem_we, dmem_addr, dmem_wdata}), 48'(d_hold));
            else d_hold = {dmem_we, dmem_addr, dmem_wdata};
            d_busy = 1'b1;
            if (!dmem_we) load_cnt++;
        end else d_busy = 1'b0;

        if (imem_valid) begin
            imem_valid = 1'b0;
            icnt = 0;
        end else if (imem_req) begin
            if (icnt >= imem_wait) begin
                imem_valid = 1'b1;
                imem_rdata = prog[imem_addr[7:0]];
            end else icnt++;
        end else icnt = 0;

        if (!dresp_en) begin
            dmem_valid = dmem_force;
            dmem_rdata = 16'hBEEF;
        end else if (dmem_valid) begin
            dmem_valid = 1'b0;
            dcnt = 0;
        end else if (dmem_req) begin
            if (dcnt >= dmem_wait) begin
                dmem_valid = 1'b1;
                if (dmem_we) begin
                    check("store_expected", 48'(st_q.size() != 0), 48'(1));
                    if (st_q.size() != 0) begin
                        s = st_q.pop_front();
                        check("store_addr_data", 48'({dmem_addr, dmem_wdata}), 48'(s));
                    end
                end else dmem_rdata = dmem_arr[dmem_addr[7:0]];
            end else dcnt++;
        end else dcnt = 0;
    end

    task automatic start_test();
        rst_n = 1'b0;
        run   = 1'b0;
        for (int i = 0; i < 256; i++) begin
            prog[i]     = '0;
            dmem_arr[i] = '0;
            m_mem[i]    = '0;
        end
        exp_q.delete();
        st_q.delete();
        m_pc = 16'h0000;
        m_a  = '0;
        m_d  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic poke(input logic [7:0] addr, input logic [15:0] val);
        dmem_arr[addr] = val;
        m_mem[addr]    = val;
    endtask

    task automatic run_prog(input int n);
        int t;
        iss_run(n);
        ret_cyc.delete();
        fetch_log.delete();
        load_cnt = 0;
        rst_n = 1'b1;
        run   = 1'b1;
        t = 0;
        while (exp_q.size() > 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("run_done_in_budget", 48'(exp_q.size()), 48'(0));
        run = 1'b0;
        repeat (20) @(negedge clk);
        check("stores_all_seen", 48'(st_q.size()), 48'(0));
    endtask

    initial begin
        int t;
        rst_n = 1'b0;
        run   = 1'b0;

        // 1: reset state, then A=5 / D=A with two-cycle latency
        start_test();
        check("rst_pc", 48'(pc), 48'(16'h0000));
        check("rst_reqs", 48'({imem_req, dmem_req, dmem_we, retire}), 48'(0));
        check("rst_regs", 48'({dec_a_reg, dec_d_reg, dec_instruction}), 48'(0));
        check("rst_mr", 48'(dec_a_mem_reg), 48'(0));
        prog[0] = 16'h0005;
        prog[1] = 16'h8490;
        run_prog(2);
        check("plain_latency", 48'(ret_gap(1)), 48'(2));

        // 2: *A = D + 1 store
        start_test();
        prog[0] = 16'h0004;
        prog[1] = 16'h8490;
        prog[2] = 16'h0010;
        prog[3] = 16'h8508;
        run_prog(4);
        check("store_latency", 48'(ret_gap(3)), 48'(3));

        // 3: D = *A + 1 with three data wait states
        start_test();
        dmem_wait = 3;
        prog[0] = 16'h0020;
        prog[1] = 16'h9550;
        poke(8'h20, 16'h0041);
        run_prog(2);
        check("load_cycles", 48'(load_cnt), 48'(4));
        check("load_latency", 48'(ret_gap(1)), 48'(6));
        check("load_mr", 48'(dec_a_mem_reg), 48'(16'h0041));
        dmem_wait = 0;

        // 4a: unconditional jump to A
        start_test();
        prog[0] = 16'h0007;
        prog[1] = 16'h8087;
        prog[7] = 16'h0001;
        run_prog(3);
        check("jump_fetch_addr", 48'(log_at(2)), 48'(16'h0007));

        // 4b: PC wraps from 16'hFFFF to 0
        start_test();
        prog[0]   = 16'h0000;
        prog[1]   = 16'h8760;
        prog[2]   = 16'h8087;
        prog[255] = 16'h0003;
        run_prog(4);
        check("fetch_ffff", 48'(log_at(3)), 48'(16'hFFFF));
        check("fetch_wrap", 48'(log_at(4)), 48'(16'h0000));

        // 5: five imem wait states
        start_test();
        imem_wait = 5;
        prog[0] = 16'h0003;
        prog[1] = 16'h0009;
        run_prog(2);
        check("stall_latency", 48'(ret_gap(1)), 48'(7));
        imem_wait = 0;

        // 6: reset while a store is waiting; a late dmem_valid must be ignored
        start_test();
        dresp_en = 1'b0;
        prog[0] = 16'h0010;
        prog[1] = 16'h8508;
        rst_n = 1'b1;
        run   = 1'b1;
        t = 0;
        while (!(dmem_req && dmem_we) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("store_reached", 48'({dmem_req, dmem_we}), 48'(2'b11));
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        run   = 1'b0;
        @(negedge clk);
        check("midrst_reqs", 48'({imem_req, dmem_req, dmem_we, retire}), 48'(0));
        check("midrst_pc", 48'(pc), 48'(16'h0000));
        check("midrst_regs", 48'({dec_a_reg, dec_instruction}), 48'(0));
        rst_n = 1'b1;
        dmem_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_valid_retire", 48'(retire), 48'(0));
        end
        dmem_force = 1'b0;
        @(negedge clk);
        check("late_valid_reqs", 48'({imem_req, dmem_req}), 48'(0));
        check("late_valid_pc", 48'(pc), 48'(16'h0000));
        check("late_valid_regs", 48'({dec_d_reg, dec_a_mem_reg}), 48'(0));
        dresp_en = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nandgame_sequencer.md
Name: nandgame_sequencer

Overview:
Multi-cycle control FSM for the nandgame CPU core.
- Fetches instruction words from instruction memory and holds the current word.
- Feeds the word, A, D and the *A operand to the external combinational decoder.
- Commits decoder results to A, D and data memory, then updates PC.
- Owns the architectural registers PC, A and D. Sits between the memory interfaces and the decoder.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  reset; synchronous, active-low
run  in  1  enable; new fetches are issued only while high
imem_req  out  1  instruction read request
imem_addr  out  16  instruction address (= PC)
imem_rdata  in  16  instruction word, valid with imem_valid
imem_valid  in  1  completes the instruction read; may arrive in the same cycle as imem_req
dmem_req  out  1  data request
dmem_we  out  1  1 = write, 0 = read
dmem_addr  out  16  data address
dmem_wdata  out  16  write data
dmem_rdata  in  16  read data, valid with dmem_valid
dmem_valid  in  1  completes the data access
dec_instruction  out  16  instruction register (IR) to decoder
dec_a_reg  out  16  A register
dec_d_reg  out  16  D register
dec_a_mem_reg  out  16  latched *A operand (MR)
dec_out  in  16  decoder result
dec_jmp  in  1  decoder jump-taken
dec_dst  in  3  decoder destination bits: [2]=A, [1]=D, [0]=*A
pc  out  16  current PC
retire  out  1  one-cycle pulse per completed instruction

Behaviour:
Reset (rst_n low at a clock edge):
- State = IDLE; PC = RESET_PC; A, D, IR, MR, store address and store data = 0.
- All req outputs = 0; retire = 0.
- Applies mid-transaction: any outstanding request is dropped at that edge, and a late valid is ignored.

States:
- IDLE:
  - run = 1 → FETCH.
  - Otherwise stay; no requests issued.
- FETCH:
  - imem_req = 1, imem_addr = PC; held stable until imem_valid.
  - On imem_valid: IR ← imem_rdata.
  - If imem_rdata[15] and imem_rdata[12] → LOAD, else → EXEC.
- LOAD:
  - dmem_req = 1, dmem_we = 0, dmem_addr = A; held until dmem_valid.
  - On dmem_valid: MR ← dmem_rdata, → EXEC.
- EXEC (exactly one cycle; decoder is combinational on IR, A, D, MR):
  - A ← dec_out if dec_dst[2].
  - D ← dec_out if dec_dst[1].
  - PC ← A(pre-update) if dec_jmp, else PC + 1 (16-bit wrap: 16'hFFFF + 1 = 0).
  - If dec_dst[0]: store address ← A(pre-update), store data ← dec_out, → STORE.
  - Otherwise: retire = 1 the next cycle, → FETCH if run, else IDLE.
- STORE:
  - dmem_req = 1, dmem_we = 1, dmem_addr / dmem_wdata = latched store address / data; held until dmem_valid.
  - Then retire = 1, → FETCH or IDLE per run.

Additional rules:
- dmem_we = 0 outside STORE.
- run is sampled only on transitions into FETCH. Deasserting run never aborts an instruction in flight.
- A-instructions (IR[15] = 0) are handled by the decoder (out = IR, dst = A); the sequencer does not special-case them.
- Latency with zero-wait memory:
  - plain instruction: 2 cycles (FETCH + EXEC)
  - with *A read: +1 cycle
  - with *A write: +1 cycle
- Wait states extend only the waiting state.
- dec_* outputs are driven continuously from registers. No output combinationally depends on dec_* or on valid inputs except through state.

Decomposition:
- Package nandgame_pkg:
  - state enum (IDLE, FETCH, LOAD, EXEC, STORE)
  - instruction bit-position constants: CI = 15, A_SEL = 12, DST field, JMP field
  - RESET_PC default
- No sub-module needed. Single FSM plus register file. The decoder is instantiated alongside at the core level, not inside this block.

Test Plan:
1. Reset, run = 1, zero-wait imem: 0x0005, 0x8490 (D = A) → after 4 cycles A = 5, D = 5, PC = 2, two retire pulses.
2. A = 0x0010, then 0x8508 (*A = D + 1, D = 4) → STORE with dmem_addr = 0x0010, dmem_wdata = 5, dmem_we = 1; A and D unchanged.
3. A = 0x0020, then 0x9550 (D = *A + 1) with memory returning 0x0041 after 3 wait cycles → LOAD held 4 cycles with stable address, then D = 0x0042.
4. A = 0x0007, then 0x8087 (unconditional jump) → next imem_addr = 0x0007. Also: PC = 0xFFFF with a non-jump instruction → next PC = 0x0000.
5. Stall imem_valid for 5 cycles → imem_req and imem_addr stable throughout; no retire until completion.
6. rst_n low during STORE wait → next cycle dmem_req = 0, state IDLE, PC = RESET_PC; a dmem_valid arriving afterwards changes nothing.
